// File: rtl/box_input_ctrl_if.sv
// Signal bundle between the board/VGA side and the box input controller.
// The controller is the slave: it takes buttons and frame_start and returns step pulses.
interface box_input_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_mode;
    logic       frame_start;
    logic       move_up;
    logic       move_down;
    logic       move_left;
    logic       move_right;
    logic       mode;
    logic [3:0] pending;
    logic [7:0] repeat_state;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_mode, frame_start,
        input  move_up, move_down, move_left, move_right, mode, pending, repeat_state
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_mode, frame_start,
        output move_up, move_down, move_left, move_right, mode, pending, repeat_state
    );
endinterface

// File: rtl/box_input_ctrl.sv
// Button conditioning (sync, debounce, auto-repeat) and frame-aligned release of box steps.
// Handshake: frame_start is a one-cycle strobe; move_* are one-cycle registered pulses, no back-pressure.
module box_input_ctrl #(
    parameter int DEBOUNCE_CYC  = 250000,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic             clk,
    input  logic             rst_n,
    box_input_ctrl_if.slave  bus
);
    localparam int MAX_A = (DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY;
    localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW    = $clog2(MAX_P);

    localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // Bit order {mode, right, left, down, up}; the low four match pending/move order.
    logic [4:0]    raw;
    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [4:0]    db;
    logic [CW-1:0] db_cnt [5];

    rep_state_t    state    [4];
    rep_state_t    state_nx [4];
    logic [CW-1:0] timer    [4];
    logic [CW-1:0] timer_nx [4];
    logic [3:0]    req;
    logic [3:0]    req_nx;

    logic          mode_db_q;
    logic          mode_rise;
    logic          mode_pend;
    logic          mode_q;
    logic [3:0]    pend;
    logic [3:0]    move_q;
    logic [3:0]    move_nx;
    logic          fs_take;

    assign raw = {bus.btn_mode, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // IDLE is only re-entered with db low, so db high while IDLE is a rising edge.
    always_comb begin
        req_nx = '0;
        for (int i = 0; i < 4; i++) begin
            state_nx[i] = state[i];
            timer_nx[i] = timer[i];
            case (state[i])
                IDLE: begin
                    if (db[i]) begin
                        req_nx[i]   = 1'b1;
                        timer_nx[i] = DELAY_LOAD;
                        state_nx[i] = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (!db[i]) begin
                        state_nx[i] = IDLE;
                    end else if (timer[i] == '0) begin
                        req_nx[i]   = 1'b1;
                        timer_nx[i] = PERIOD_LOAD;
                        state_nx[i] = REPEAT;
                    end else begin
                        timer_nx[i] = timer[i] - 1'b1;
                    end
                end
                default: state_nx[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req <= '0;
            for (int i = 0; i < 4; i++) begin
                state[i] <= IDLE;
                timer[i] <= '0;
            end
        end else begin
            req <= req_nx;
            for (int i = 0; i < 4; i++) begin
                state[i] <= state_nx[i];
                timer[i] <= timer_nx[i];
            end
        end
    end

    assign mode_rise = db[4] & ~mode_db_q;
    // A strobe right after an emitted pulse is held off so move_* can never repeat back to back.
    assign fs_take   = bus.frame_start & ~(|move_q);

    // Up/down cancellation is checked first; left/right only when up/down did not cancel.
    always_comb begin
        move_nx = '0;
        if (fs_take && !mode_pend) begin
            if (pend[0] && pend[1]) begin
                move_nx = {pend[3:2], 2'b00};
            end else if (pend[2] && pend[3]) begin
                move_nx = {2'b00, pend[1:0]};
            end else begin
                move_nx = pend;
            end
        end
    end

    // Requests arriving with the strobe are OR-ed in after the clear, so they wait a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_db_q <= 1'b0;
            mode_pend <= 1'b0;
            mode_q    <= 1'b0;
            pend      <= '0;
            move_q    <= '0;
        end else begin
            mode_db_q <= db[4];
            mode_pend <= (fs_take ? 1'b0 : mode_pend) | mode_rise;
            mode_q    <= mode_q ^ (fs_take & mode_pend);
            pend      <= (fs_take ? 4'b0000 : pend) | req;
            move_q    <= move_nx;
        end
    end

    assign bus.move_up      = move_q[0];
    assign bus.move_down    = move_q[1];
    assign bus.move_left    = move_q[2];
    assign bus.move_right   = move_q[3];
    assign bus.mode         = mode_q;
    assign bus.pending      = pend;
    assign bus.repeat_state = {state[3], state[2], state[1], state[0]};
endmodule

// File: tb/tb_box_input_ctrl.sv
// Directed, table-driven bench for box_input_ctrl with small debounce/repeat parameters.
module tb_box_input_ctrl;
    localparam int DB   = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int HOLD = 200;

    typedef struct {
        logic [4:0] btns;   // {mode, right, left, down, up}
        logic [3:0] pend;   // pending after press and release
        logic [3:0] move;   // move pulses at N+1
        logic       mode;   // mode at N+1
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fs_man = 1'b0;
    logic fs_gen = 1'b0;
    logic gen_en = 1'b0;
    int   gen_period = 50;
    int   tests = 0;
    int   fails = 0;
    int   mv_cnt [4] = '{default: 0};
    logic [3:0] prev_mv = 4'b0000;
    logic [3:0] exp_q [$];
    vec_t vecs [10];

    box_input_ctrl_if bus ();

    box_input_ctrl #(
        .DEBOUNCE_CYC  (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.frame_start = fs_man | fs_gen;

    wire [3:0] mv = {bus.move_right, bus.move_left, bus.move_down, bus.move_up};

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [4:0] b);
        bus.btn_up    = b[0];
        bus.btn_down  = b[1];
        bus.btn_left  = b[2];
        bus.btn_right = b[3];
        bus.btn_mode  = b[4];
    endtask

    task automatic frame();
        fs_man = 1'b1;
        tick(1);
        fs_man = 1'b0;
    endtask

    function automatic int total_moves();
        return mv_cnt[0] + mv_cnt[1] + mv_cnt[2] + mv_cnt[3];
    endfunction

    // Free-running frame strobe for the long scenarios
    initial begin
        int gcnt;
        gcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (gen_en) begin
                gcnt++;
                if (gcnt >= gen_period) gcnt = 0;
                fs_gen = (gcnt == 0);
            end else begin
                gcnt = 0;
                fs_gen = 1'b0;
            end
        end
    end

    // Pulse monitor: counts moves and rejects back-to-back highs
    always @(negedge clk) begin
        if (prev_mv != 4'b0000) check("no_back_to_back", 32'(mv & prev_mv), 32'd0);
        for (int i = 0; i < 4; i++) if (mv[i]) mv_cnt[i]++;
        prev_mv = mv;
    end

    initial begin
        int base;
        int exp_n;
        logic [3:0] any_pend;
        logic [3:0] exp_m;

        vecs[0] = '{5'b00001, 4'b0001, 4'b0001, 1'b0};
        vecs[1] = '{5'b00100, 4'b0100, 4'b0100, 1'b0};
        vecs[2] = '{5'b00011, 4'b0011, 4'b0000, 1'b0};
        vecs[3] = '{5'b01100, 4'b1100, 4'b0000, 1'b0};
        vecs[4] = '{5'b01001, 4'b1001, 4'b1001, 1'b0};
        vecs[5] = '{5'b10001, 4'b0001, 4'b0000, 1'b1};
        vecs[6] = '{5'b00110, 4'b0110, 4'b0110, 1'b1};
        vecs[7] = '{5'b10000, 4'b0000, 4'b0000, 1'b0};
        vecs[8] = '{5'b00111, 4'b0111, 4'b0100, 1'b0};
        vecs[9] = '{5'b10000, 4'b0000, 4'b0000, 1'b1};

        set_btns(5'b00000);
        tick(3);
        check("reset_pending", 32'(bus.pending), 32'd0);
        check("reset_moves", 32'(mv), 32'd0);
        check("reset_mode", 32'(bus.mode), 32'd0);
        check("reset_state", 32'(bus.repeat_state), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // Glitch of DB-1 cycles must vanish
        base = mv_cnt[0];
        any_pend = 4'b0000;
        bus.btn_up = 1'b1;
        tick(DB - 1);
        bus.btn_up = 1'b0;
        gen_period = 50;
        gen_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            any_pend = any_pend | bus.pending;
        end
        gen_en = 1'b0;
        tick(3);
        check("glitch_pending", 32'(any_pend), 32'd0);
        check("glitch_moves", 32'(mv_cnt[0] - base), 32'd0);

        for (int v = 0; v < 10; v++) begin
            set_btns(vecs[v].btns);
            tick(10);
            set_btns(5'b00000);
            tick(12);
            check($sformatf("vec%0d_pending", v), 32'(bus.pending), 32'(vecs[v].pend));
            base = total_moves();
            exp_q.push_back(vecs[v].move);
            frame();
            exp_m = exp_q.pop_front();
            check($sformatf("vec%0d_move", v), 32'(mv), 32'(exp_m));
            check($sformatf("vec%0d_pend_clr", v), 32'(bus.pending), 32'd0);
            check($sformatf("vec%0d_mode", v), 32'(bus.mode), 32'(vecs[v].mode));
            tick(1);
            check($sformatf("vec%0d_move_off", v), 32'(mv), 32'd0);
            tick(3);
            check($sformatf("vec%0d_move_count", v), 32'(total_moves() - base), 32'($countones(exp_m)));
        end

        // Auto-repeat: first req 2+DB+1 after press, db drops HOLD+2+DB after press
        exp_n = 1;
        for (int t = 2 + DB + 1 + RD; t <= HOLD + 2 + DB; t += RP) exp_n++;
        base = mv_cnt[3];
        gen_period = 5;
        gen_en = 1'b1;
        bus.btn_right = 1'b1;
        tick(HOLD);
        bus.btn_right = 1'b0;
        tick(60);
        gen_en = 1'b0;
        tick(5);
        check("repeat_count", 32'(mv_cnt[3] - base), 32'(exp_n));
        check("repeat_pend_clr", 32'(bus.pending), 32'd0);

        // req lands in the frame_start cycle: held over to the next frame
        bus.btn_down = 1'b1;
        tick(2 + DB + 1);
        fs_man = 1'b1;
        tick(1);
        fs_man = 1'b0;
        check("coinc_no_move", 32'(mv), 32'd0);
        check("coinc_pending", 32'(bus.pending), 32'b0010);
        tick(2);
        bus.btn_down = 1'b0;
        tick(12);
        frame();
        check("coinc_next_move", 32'(mv), 32'b0010);
        check("coinc_pend_clr", 32'(bus.pending), 32'd0);

        // Asynchronous reset in DELAY, button held through release
        bus.btn_left = 1'b1;
        tick(12);
        check("pre_rst_state", 32'(bus.repeat_state[5:4]), 32'd1);
        check("pre_rst_pending", 32'(bus.pending), 32'b0100);
        check("pre_rst_mode", 32'(bus.mode), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_pending", 32'(bus.pending), 32'd0);
        check("async_rst_moves", 32'(mv), 32'd0);
        check("async_rst_mode", 32'(bus.mode), 32'd0);
        check("async_rst_state", 32'(bus.repeat_state), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2 + DB + 1);
        check("held_not_yet", 32'(bus.pending), 32'd0);
        check("held_state", 32'(bus.repeat_state[5:4]), 32'd1);
        tick(1);
        check("held_pending", 32'(bus.pending), 32'b0100);
        tick(2);
        bus.btn_left = 1'b0;
        tick(12);
        base = total_moves();
        frame();
        check("held_move", 32'(mv), 32'b0100);
        tick(3);
        check("held_move_count", 32'(total_moves() - base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
